// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch sequencer: accepts one branch, waits out operand hazards,
// drives the external comparator and redirects fetch on an aligned taken branch.
module branch_resolve_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_kind,
   input  logic [31:0]      br_pc,
   input  logic [31:0]      br_imm,
   input  logic [31:0]      br_rs1_data,
   input  logic [31:0]      br_rs2_data,
   input  logic             br_hazard,
   input  logic             flush_in,
   output logic [31:0]      cmp_op1,
   output logic [31:0]      cmp_op2,
   output logic [2:0]       cmp_kind,
   input  logic             cmp_result,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [31:0]      redirect_pc,
   output logic             resolved,
   output logic             resolved_taken,
   output logic             misalign_err,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned KIND_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_OPS,
      COMPARE,
      REDIRECT
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   imm_q;
   logic [KIND_W-1:0] kind_q;
   logic [XLEN-1:0]   target_c;
   logic              accept_c;

   assign target_c = pc_q + imm_q;
   assign accept_c = br_valid && (state == IDLE) && !flush_in;
   // Ready is held low while reset is asserted even though the state already reads IDLE.
   assign br_ready = rst_n && (state == IDLE) && !flush_in;

   // Sequencer: state, latched branch context, comparator drive, pulses and statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc_q           <= '0;
         imm_q          <= '0;
         kind_q         <= '0;
         cmp_op1        <= '0;
         cmp_op2        <= '0;
         cmp_kind       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         resolved       <= 1'b0;
         resolved_taken <= 1'b0;
         misalign_err   <= 1'b0;
         br_count       <= '0;
         taken_count    <= '0;
      end else begin
         resolved       <= 1'b0;
         resolved_taken <= 1'b0;
         misalign_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  pc_q   <= br_pc;
                  imm_q  <= br_imm;
                  kind_q <= br_kind;
                  if (!br_hazard) begin
                     cmp_op1  <= br_rs1_data;
                     cmp_op2  <= br_rs2_data;
                     cmp_kind <= br_kind;
                     state    <= COMPARE;
                  end else begin
                     state    <= WAIT_OPS;
                  end
               end
            end
            WAIT_OPS: begin
               if (flush_in) begin
                  state <= IDLE;
               end else if (!br_hazard) begin
                  cmp_op1  <= br_rs1_data;
                  cmp_op2  <= br_rs2_data;
                  cmp_kind <= kind_q;
                  state    <= COMPARE;
               end
            end
            COMPARE: begin
               cmp_kind <= '0;
               state    <= IDLE;
               if (!flush_in) begin
                  resolved <= 1'b1;
                  if (br_count != '1) br_count <= br_count + CNT_W'(1);
                  if (cmp_result) begin
                     resolved_taken <= 1'b1;
                     if (taken_count != '1) taken_count <= taken_count + CNT_W'(1);
                     if (target_c[1:0] != 2'b00) begin
                        misalign_err <= 1'b1;
                     end else begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target_c;
                        state          <= REDIRECT;
                     end
                  end
               end
            end
            REDIRECT: begin
               if (flush_in || redirect_ready) begin
                  redirect_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized bench for branch_resolve_ctrl against a cycle-indexed transaction model;
// a second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid, br_hazard, flush_in, redirect_ready;
   logic [2:0]  br_kind;
   logic [31:0] br_pc, br_imm, br_rs1_data, br_rs2_data;

   logic        br_ready, cmp_result, redirect_valid, resolved, resolved_taken, misalign_err;
   logic [31:0] cmp_op1, cmp_op2, redirect_pc;
   logic [2:0]  cmp_kind;
   logic [15:0] br_count, taken_count;

   logic        br_ready4, cmp_result4, redirect_valid4, resolved4, resolved_taken4, misalign_err4;
   logic [31:0] cmp_op1_4, cmp_op2_4, redirect_pc4;
   logic [2:0]  cmp_kind4;
   logic [3:0]  br_count4, taken_count4;

   int n_checks = 0;
   int n_err    = 0;
   int m_br = 0, m_tk = 0, m_br4 = 0, m_tk4 = 0;

   always #5 clk = ~clk;

   // External comparator behaviour.
   function automatic logic cmp_fn(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b);
      case (k)
         3'd1:    return a == b;
         3'd2:    return a != b;
         3'd3:    return a >= b;
         3'd4:    return a < b;
         default: return 1'b0;
      endcase
   endfunction

   assign cmp_result  = cmp_fn(cmp_kind, cmp_op1, cmp_op2);
   assign cmp_result4 = cmp_fn(cmp_kind4, cmp_op1_4, cmp_op2_4);

   branch_resolve_ctrl #(.CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready), .br_kind(br_kind),
      .br_pc(br_pc), .br_imm(br_imm), .br_rs1_data(br_rs1_data), .br_rs2_data(br_rs2_data),
      .br_hazard(br_hazard), .flush_in(flush_in), .cmp_op1(cmp_op1), .cmp_op2(cmp_op2),
      .cmp_kind(cmp_kind), .cmp_result(cmp_result), .redirect_valid(redirect_valid),
      .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .resolved(resolved),
      .resolved_taken(resolved_taken), .misalign_err(misalign_err), .br_count(br_count),
      .taken_count(taken_count)
   );

   branch_resolve_ctrl #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready4), .br_kind(br_kind),
      .br_pc(br_pc), .br_imm(br_imm), .br_rs1_data(br_rs1_data), .br_rs2_data(br_rs2_data),
      .br_hazard(br_hazard), .flush_in(flush_in), .cmp_op1(cmp_op1_4), .cmp_op2(cmp_op2_4),
      .cmp_kind(cmp_kind4), .cmp_result(cmp_result4), .redirect_valid(redirect_valid4),
      .redirect_ready(redirect_ready), .redirect_pc(redirect_pc4), .resolved(resolved4),
      .resolved_taken(resolved_taken4), .misalign_err(misalign_err4), .br_count(br_count4),
      .taken_count(taken_count4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_counters();
      chk("br_count", 32'(br_count), 32'(m_br));
      chk("taken_count", 32'(taken_count), 32'(m_tk));
      chk("br_count4", 32'(br_count4), 32'(m_br4));
      chk("taken_count4", 32'(taken_count4), 32'(m_tk4));
   endtask

   // One branch; cycle c is the interval after the c-th edge following acceptance.
   // nhaz = hazard cycles counted from acceptance, rdy_wait = cycles redirect_ready
   // stays low, f = cycle in which flush_in is raised (-1 for none).
   task automatic do_branch(input logic [2:0] kind, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input int nhaz, input int rdy_wait, input int f);
      logic [31:0] tgt;
      logic        taken, mis, redir, flushed, in_cmp, exp_res;
      int          rc, red_end, end_c;
      tgt     = pc + imm;
      taken   = cmp_fn(kind, rs1, rs2);
      mis     = taken && (tgt[1:0] != 2'b00);
      rc      = nhaz + 1;
      red_end = rc + rdy_wait;
      flushed = (f >= 0) && (f < rc);
      redir   = taken && !mis && !flushed;
      if (flushed)                      end_c = f + 1;
      else if (!redir)                  end_c = rc;
      else if (f >= rc && f <= red_end) end_c = f + 1;
      else                              end_c = red_end + 1;

      br_valid = 1'b1; br_kind = kind; br_pc = pc; br_imm = imm;
      br_hazard = (nhaz > 0); flush_in = 1'b0; redirect_ready = 1'b0;
      br_rs1_data = (nhaz == 0) ? rs1 : $urandom;
      br_rs2_data = (nhaz == 0) ? rs2 : $urandom;
      #1 chk("accept_ready", 32'(br_ready), 32'd1);

      for (int c = 0; c <= end_c; c++) begin
         @(posedge clk); #1;
         br_valid = (c < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
         br_kind = 3'($urandom); br_pc = $urandom; br_imm = $urandom;
         br_hazard = (c < nhaz - 1);
         br_rs1_data = (c == nhaz - 1) ? rs1 : $urandom;
         br_rs2_data = (c == nhaz - 1) ? rs2 : $urandom;
         flush_in = (c == f) && (c < end_c);
         redirect_ready = redir && (c == red_end);
         #1;
         exp_res = (c == rc) && !flushed;
         if (exp_res) begin
            m_br  = (m_br  < 65535) ? m_br + 1  : m_br;
            m_br4 = (m_br4 < 15)    ? m_br4 + 1 : m_br4;
            if (taken) begin
               m_tk  = (m_tk  < 65535) ? m_tk + 1  : m_tk;
               m_tk4 = (m_tk4 < 15)    ? m_tk4 + 1 : m_tk4;
            end
         end
         in_cmp = (c == nhaz) && !((f >= 0) && (f < nhaz));
         chk("br_ready", 32'(br_ready), 32'(c == end_c));
         chk("cmp_kind", 32'(cmp_kind), in_cmp ? 32'(kind) : 32'd0);
         if (in_cmp) begin
            chk("cmp_op1", cmp_op1, rs1);
            chk("cmp_op2", cmp_op2, rs2);
         end
         chk("resolved", 32'(resolved), 32'(exp_res));
         chk("resolved_taken", 32'(resolved_taken), 32'(exp_res && taken));
         chk("misalign_err", 32'(misalign_err), 32'(exp_res && mis));
         chk("redirect_valid", 32'(redirect_valid), 32'(redir && c >= rc && c < end_c));
         if (redir && c >= rc && c < end_c) chk("redirect_pc", redirect_pc, tgt);
         chk_counters();
      end
      flush_in = 1'b0; redirect_ready = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         br_valid = 1'b0;
         flush_in = 1'($urandom_range(0, 1));
         #1;
         chk("idle_ready", 32'(br_ready), 32'(!flush_in));
         chk("idle_resolved", 32'(resolved), 32'd0);
         chk("idle_redirect", 32'(redirect_valid), 32'd0);
      end
      flush_in = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(br_ready), 32'd0);
      chk({tag, "_cmp"}, {cmp_op1 | cmp_op2 | 32'(cmp_kind)}, 32'd0);
      chk({tag, "_redir"}, 32'(redirect_valid) | redirect_pc, 32'd0);
      chk({tag, "_pulses"}, 32'({resolved, resolved_taken, misalign_err}), 32'd0);
      chk({tag, "_cmp4"}, {cmp_op1_4 | cmp_op2_4 | 32'(cmp_kind4)}, 32'd0);
      chk({tag, "_ready4"}, 32'(br_ready4), 32'd0);
      chk_counters();
   endtask

   initial begin
      logic [2:0]  k;
      logic [31:0] a, b, p, im;
      int          nh, rw, fl;
      rst_n = 1'b0; br_valid = 1'b0; br_hazard = 1'b0; flush_in = 1'b0; redirect_ready = 1'b0;
      br_kind = '0; br_pc = '0; br_imm = '0; br_rs1_data = '0; br_rs2_data = '0;
      #3 chk_all_zero("reset");
      #14 rst_n = 1'b1;
      #1 chk("release_ready", 32'(br_ready), 32'd1);
      @(posedge clk); #1;

      do_branch(3'd1, 32'h100, 32'h20, 32'h1234, 32'h1234, 0, 3, -1);
      do_branch(3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0, -1);
      do_branch(3'd2, 32'h300, 32'h10, 32'd5, 32'd6, 3, 1, -1);
      do_branch(3'd1, 32'h100, 32'h6, 32'd9, 32'd9, 0, 0, -1);
      idle_cycles(2);
      do_branch(3'd1, 32'h400, 32'h8, 32'd7, 32'd7, 0, 2, 3);
      do_branch(3'd3, 32'h500, 32'h4, 32'd8, 32'd2, 4, 0, 1);
      do_branch(3'd4, 32'h600, 32'h4, 32'd1, 32'd2, 0, 0, 0);
      idle_cycles(3);

      // Asynchronous reset in the middle of COMPARE.
      br_valid = 1'b1; br_kind = 3'd1; br_pc = 32'h700; br_imm = 32'h10;
      br_rs1_data = 32'hABCD; br_rs2_data = 32'hABCD; br_hazard = 1'b0;
      @(posedge clk); #1;
      br_valid = 1'b0;
      chk("pre_reset_cmp_kind", 32'(cmp_kind), 32'd1);
      #2 rst_n = 1'b0;
      m_br = 0; m_tk = 0; m_br4 = 0; m_tk4 = 0;
      #1 chk_all_zero("midreset");
      @(negedge clk) rst_n = 1'b1;
      #1 chk("post_reset_ready", 32'(br_ready), 32'd1);
      @(posedge clk); #1;
      chk("post_reset_ready_edge", 32'(br_ready), 32'd1);
      chk("post_reset_resolved", 32'(resolved), 32'd0);

      // 17 taken branches: 4-bit counters must stick at all-ones.
      for (int i = 0; i < 17; i++) begin
         a = $urandom;
         do_branch(3'd1, {$urandom} & 32'hFFFF_FFFC, ({$urandom} & 32'hFFC) | 32'(i % 2 * 2),
                   a, a, 0, 0, -1);
      end
      chk("sat_br4", 32'(br_count4), 32'hF);
      chk("sat_tk4", 32'(taken_count4), 32'hF);

      for (int i = 0; i < 60; i++) begin
         k  = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
         p  = {$urandom} & 32'hFFFF_FFFC;
         im = ($urandom_range(0, 3) == 0) ? {$urandom} : ({$urandom} & 32'hFFFF_FFFC);
         nh = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         rw = $urandom_range(0, 3);
         fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nh + rw + 2) : -1;
         do_branch(k, p, im, a, b, nh, rw, fl);
         if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequencing controller for the branch comparator in the RISC-V execute stage. It accepts one conditional branch at a time from decode over a valid/ready handshake and waits out operand hazards. It drives the external comparator's operand and kind inputs from registered values, samples its single-bit result, and issues a PC redirect to fetch when the branch is taken. It also flags misaligned targets and keeps saturating branch and taken statistics.

## Interface
- `CNT_W`, default 16: width of statistics counters.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `br_valid` input 1: branch request valid.
- `br_ready` output 1: controller can accept a branch.
- `br_kind` input 3: 001 BEQ, 010 BNE, 011 BGE (unsigned), 100 BLT (unsigned); other codes never take.
- `br_pc` input 32: PC of the branch.
- `br_imm` input 32: sign-extended byte offset.
- `br_rs1_data` input 32: operand 1, forwarded.
- `br_rs2_data` input 32: operand 2, forwarded.
- `br_hazard` input 1: forwarded operands not yet valid.
- `flush_in` input 1: pipeline flush; abandons any in-flight branch.
- `cmp_op1` output 32: comparator operand 1.
- `cmp_op2` output 32: comparator operand 2.
- `cmp_kind` output 3: comparator kind.
- `cmp_result` input 1: comparator should-branch, combinational from the `cmp_*` outputs.
- `redirect_valid` output 1: redirect request to fetch.
- `redirect_ready` input 1: fetch accepts the redirect.
- `redirect_pc` output 32: branch target.
- `resolved` output 1: one-cycle pulse when a branch completes.
- `resolved_taken` output 1: outcome, valid with `resolved`.
- `misalign_err` output 1: one-cycle pulse when a taken target has `[1:0]` != 0.
- `br_count` output CNT_W: resolved branches, saturating.
- `taken_count` output CNT_W: taken branches, saturating; includes misaligned branches.

## Operation
- The FSM has four states: IDLE, WAIT_OPS, COMPARE, REDIRECT.
- **IDLE**
  - `br_ready` = !flush_in.
  - Acceptance requires br_valid && br_ready. On acceptance, latch pc, imm and kind.
  - If br_hazard = 0: latch rs1/rs2 and go to COMPARE.
  - If br_hazard = 1: go to WAIT_OPS.
- **WAIT_OPS**
  - Stay while br_hazard = 1, with no timeout.
  - In the first cycle br_hazard = 0: latch rs1/rs2 and go to COMPARE.
- **COMPARE**
  - `cmp_op1`/`cmp_op2`/`cmp_kind` are driven from the latched registers. `cmp_result` is sampled at the end of the cycle.
  - Target is pc + imm, modulo 2^32.
  - Not taken: pulse `resolved`, `resolved_taken` = 0, go to IDLE.
  - Taken with target[1:0] != 0: pulse `resolved`, `resolved_taken` = 1 and `misalign_err`. No redirect; go to IDLE.
  - Taken and aligned: pulse `resolved`, `resolved_taken` = 1, load `redirect_pc`, go to REDIRECT.
- **REDIRECT**
  - `redirect_valid` = 1 and `redirect_pc` is held stable until redirect_ready = 1, then go to IDLE.
- Outside COMPARE, `cmp_kind` = 000, so the comparator output is 0. `cmp_op1`/`cmp_op2` hold their last values.
- **Counters:** `br_count`++ on each `resolved`; `taken_count`++ on each `resolved_taken`. Both stick at all-ones.
- **flush_in = 1**
  - In WAIT_OPS, COMPARE or REDIRECT: go to IDLE next cycle.
  - No `resolved`, `misalign_err` or `redirect_valid` is produced for the abandoned branch, and counters do not change.
  - Flush takes priority over every other transition, including redirect_ready.

## Timing
- **Reset:** all outputs are 0 and counters are 0. `br_ready` = 0 while rst_n = 0. The state is IDLE asynchronously, mid-operation included. `br_ready` = 1 in the first cycle after release, unless flush_in is asserted.
- `resolved`, `resolved_taken`, `misalign_err` and `redirect_valid` are registered outputs.
- **Latency**, with acceptance at edge T and no hazard:
  - COMPARE occupies cycle T..T+1.
  - `resolved` is high in cycle T+1..T+2.
  - `redirect_valid` rises with `resolved`.
  - Next acceptance is possible at edge T+2 when not taken, or at the edge after redirect_ready when taken.
- Each hazard cycle adds one cycle of latency.
- `br_ready` is 0 in every state except IDLE. There is no back-to-back acceptance, so throughput is at most one branch per 2 cycles.
- `redirect_valid` must not drop before redirect_ready unless flush_in = 1.

## Test plan
- BEQ: rs1 = rs2 = 0x1234, pc = 0x100, imm = 0x20, no hazard. Required: `resolved` and `resolved_taken` at T+1; `redirect_valid` with `redirect_pc` = 0x120; held 3 cycles with redirect_ready = 0, then drops one cycle after redirect_ready = 1.
- BLT unsigned: rs1 = 0xFFFFFFFF, rs2 = 1. Required: not taken, `resolved_taken` = 0, no redirect, `br_count` = 1, `taken_count` = 0.
- Hazard: br_hazard high for 3 cycles after acceptance while rs1 changes, then BNE with 5 vs 6. Required: comparison uses the values sampled when the hazard cleared; `resolved` at T+4; taken.
- Misaligned target: BEQ taken, pc = 0x100, imm = 0x6. Required: `misalign_err` and `resolved` pulse together, `redirect_valid` stays 0, back in IDLE.
- Flush in REDIRECT with redirect_ready = 1 in the same cycle, then flush in WAIT_OPS. Required: IDLE next cycle; no further `resolved`; counters unchanged by the WAIT_OPS flush.
- Async reset asserted mid-COMPARE. Required: all outputs 0 immediately; counters cleared; `br_ready` = 1 the cycle after release. Also with CNT_W = 4: 17 taken branches leave both counters at 0xF.
